// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encodings as decoded from BYTE_SEL
//   - FSM state constants
//   - byte-enable constants
//   - helpers for size normalisation and alignment checking
package lsu_pkg;

   // Access sizes; BYTE_SEL=2'b11 is folded onto SIZE_W by norm_size().
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // FSM states.
   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t IDLE = 2'd0;
   localparam lsu_state_t BUSY = 2'd1;
   localparam lsu_state_t DONE = 2'd2;

   // Byte-enable patterns.
   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   function automatic logic [1:0] norm_size(input logic [1:0] byte_sel);
      logic [1:0] size;
      size = (byte_sel == 2'b11) ? SIZE_W : byte_sel;
      return size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SIZE_H:  mis = off[0];
         SIZE_W:  mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte or halfword lane out of a
// 32-bit bus word and sign- or zero-extends it; words pass through.
//   rdata_i  bus read data
//   size_i   normalised access size (SIZE_B/SIZE_H/SIZE_W)
//   off_i    byte offset within the word
//   sign_i   1 = sign-extend, 0 = zero-extend
//   data_o   formatted load result
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        sign_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (off_i)
         2'd0:    byte_lane = rdata_i[7:0];
         2'd1:    byte_lane = rdata_i[15:8];
         2'd2:    byte_lane = rdata_i[23:16];
         default: byte_lane = rdata_i[31:24];
      endcase
      half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (size_i)
         SIZE_B:  data_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
         SIZE_H:  data_o = {{16{sign_i & half_lane[15]}}, half_lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one memory access at a time on a req/ack bus,
// stalls the core until completion and returns formatted load data.
//   CLK, RST_N                          clock, async active-low reset
//   MEM_READ, MEM_WRITE                 access request (held until LSU_DONE)
//   BYTE_SEL, SIGN, ADDR, WDATA         access size, extension, address, store data
//   RDATA_OUT                           last successful load result
//   LSU_STALL, LSU_DONE                 pipeline hold, one-cycle completion pulse
//   MISALIGN, BUS_TIMEOUT               abort reasons, valid with LSU_DONE
//   BUS_REQ/WE/ADDR/BE/WDATA            data-memory request side
//   BUS_ACK, BUS_RDATA                  data-memory response side
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              MEM_READ,
   input  logic              MEM_WRITE,
   input  logic [1:0]        BYTE_SEL,
   input  logic              SIGN,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic [DATA_W-1:0] RDATA_OUT,
   output logic              LSU_STALL,
   output logic              LSU_DONE,
   output logic              MISALIGN,
   output logic              BUS_TIMEOUT,
   output logic              BUS_REQ,
   output logic              BUS_WE,
   output logic [ADDR_W-1:0] BUS_ADDR,
   output logic [3:0]        BUS_BE,
   output logic [DATA_W-1:0] BUS_WDATA,
   input  logic              BUS_ACK,
   input  logic [DATA_W-1:0] BUS_RDATA
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   // Last BUSY cycle index before an unacknowledged access is abandoned.
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

   lsu_state_t        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [1:0]        off_q, off_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mis_q, mis_d;
   logic              tmo_q, tmo_d;

   logic [1:0]        req_size;
   logic [3:0]        req_be;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] load_data;

   // Lane selection for the incoming request, captured at the accept edge.
   always_comb begin
      req_size = norm_size(BYTE_SEL);
      case (req_size)
         SIZE_B: begin
            req_be    = BE_BYTE0 << ADDR[1:0];
            req_wdata = {4{WDATA[7:0]}};
         end
         SIZE_H: begin
            req_be    = ADDR[1] ? BE_HALF_HI : BE_HALF_LO;
            req_wdata = {2{WDATA[15:0]}};
         end
         default: begin
            req_be    = BE_WORD;
            req_wdata = WDATA;
         end
      endcase
   end

   lsu_load_align u_load_align (
      .rdata_i (BUS_RDATA),
      .size_i  (size_q),
      .off_i   (off_q),
      .sign_i  (sign_q),
      .data_o  (load_data)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sign_d  = sign_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      tmo_d   = tmo_q;

      case (state_q)
         IDLE: begin
            mis_d = 1'b0;
            tmo_d = 1'b0;
            cnt_d = '0;
            if (MEM_READ | MEM_WRITE) begin
               if (is_misaligned(req_size, ADDR[1:0])) begin
                  // Abort without touching the bus.
                  state_d = DONE;
                  mis_d   = 1'b1;
               end else begin
                  state_d = BUSY;
                  we_d    = MEM_WRITE;
                  addr_d  = {ADDR[ADDR_W-1:2], 2'b00};
                  be_d    = req_be;
                  wdata_d = req_wdata;
                  size_d  = req_size;
                  sign_d  = SIGN;
                  off_d   = ADDR[1:0];
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CntW'(1);
            // Ack is checked first so an ack on the final cycle still completes.
            if (BUS_ACK) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = load_data;
               end
            end else if (cnt_q == TimeoutLast) begin
               state_d = DONE;
               tmo_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= BE_NONE;
         wdata_q <= '0;
         size_q  <= SIZE_B;
         sign_q  <= 1'b0;
         off_q   <= 2'b00;
         cnt_q   <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         tmo_q   <= tmo_d;
      end
   end

   // Bus strobes are qualified by BUSY so they fall straight away on reset.
   assign BUS_REQ     = (state_q == BUSY);
   assign BUS_WE      = BUS_REQ & we_q;
   assign BUS_BE      = BUS_REQ ? be_q : BE_NONE;
   assign BUS_ADDR    = addr_q;
   assign BUS_WDATA   = wdata_q;
   assign LSU_DONE    = (state_q == DONE);
   assign MISALIGN    = LSU_DONE & mis_q;
   assign BUS_TIMEOUT = LSU_DONE & tmo_q;
   assign RDATA_OUT   = rdata_q;
   assign LSU_STALL   = (MEM_READ | MEM_WRITE) & ~LSU_DONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses, a memory
// responder with programmable wait states, and a scoreboard monitor.
module tb_load_store_unit;

   localparam int unsigned TO = 4;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        MEM_READ, MEM_WRITE, SIGN;
   logic [1:0]  BYTE_SEL;
   logic [31:0] ADDR, WDATA;
   logic [31:0] RDATA_OUT;
   logic        LSU_STALL, LSU_DONE, MISALIGN, BUS_TIMEOUT;
   logic        BUS_REQ, BUS_WE;
   logic [31:0] BUS_ADDR, BUS_WDATA;
   logic [3:0]  BUS_BE;
   logic        BUS_ACK;
   logic [31:0] BUS_RDATA;

   always #5 CLK = ~CLK;

   load_store_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .MEM_READ    (MEM_READ),
      .MEM_WRITE   (MEM_WRITE),
      .BYTE_SEL    (BYTE_SEL),
      .SIGN        (SIGN),
      .ADDR        (ADDR),
      .WDATA       (WDATA),
      .RDATA_OUT   (RDATA_OUT),
      .LSU_STALL   (LSU_STALL),
      .LSU_DONE    (LSU_DONE),
      .MISALIGN    (MISALIGN),
      .BUS_TIMEOUT (BUS_TIMEOUT),
      .BUS_REQ     (BUS_REQ),
      .BUS_WE      (BUS_WE),
      .BUS_ADDR    (BUS_ADDR),
      .BUS_BE      (BUS_BE),
      .BUS_WDATA   (BUS_WDATA),
      .BUS_ACK     (BUS_ACK),
      .BUS_RDATA   (BUS_RDATA)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          req_cycles;
      logic        mis;
      logic        tmo;
      logic [31:0] rdata_out;
   } exp_t;

   typedef struct {
      int          delay;
      logic [31:0] rdata;
   } rsp_t;

   exp_t        exp_q[$];
   rsp_t        rsp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   logic [31:0] model_rdata = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load formatting from plain shift/mask arithmetic.
   function automatic logic [31:0] load_result(input int size, input bit sign, input int off,
                                               input logic [31:0] rd);
      logic [31:0] v;
      if (size == 0) begin
         v = (rd >> (8 * off)) & 32'hFF;
         if (sign && v >= 128) v = v - 256;
      end else if (size == 1) begin
         v = (rd >> (8 * off)) & 32'hFFFF;
         if (sign && v >= 32768) v = v - 65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Issue one access from an IDLE negedge and wait (bounded) for completion.
   task automatic do_txn(input bit re, input bit we, input int size, input bit sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay);
      exp_t e;
      rsp_t r;
      int   off, sz, lat, exp_lat;
      bit   mis;
      off = int'(addr & 32'h3);
      sz  = (size == 3) ? 2 : size;
      mis = (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
      e.we    = we;
      e.addr  = addr & ~32'h3;
      e.be    = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? (4'b0011 << off) : 4'hF;
      e.wdata = (sz == 0) ? (wdata & 32'hFF) * 32'h01010101 :
                (sz == 1) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
      e.mis   = mis;
      e.tmo   = !mis && delay >= int'(TO);
      e.req_cycles = mis ? 0 : (delay >= int'(TO) ? int'(TO) : delay + 1);
      if (!mis && !e.tmo && !we) model_rdata = load_result(sz, sign, off, rdata);
      e.rdata_out = model_rdata;
      exp_q.push_back(e);
      if (!mis) begin
         r.delay = delay;
         r.rdata = rdata;
         rsp_q.push_back(r);
      end
      exp_lat = mis ? 1 : e.req_cycles + 1;

      MEM_READ  = re;
      MEM_WRITE = we;
      BYTE_SEL  = size[1:0];
      SIGN      = sign;
      ADDR      = addr;
      WDATA     = wdata;
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
         if (!LSU_DONE) check("stall_while_busy", LSU_STALL, 1);
      end while (!LSU_DONE && lat < 50);
      check("done_latency", lat, exp_lat);
      check("stall_at_done", LSU_STALL, 0);
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge CLK);
   endtask

   // Memory responder: acks on BUSY cycle delay+1, random ack noise otherwise.
   initial begin
      int   cyc;
      rsp_t cur;
      cyc = 0;
      cur.delay = 1000;
      cur.rdata = 32'h0;
      BUS_ACK   = 1'b0;
      BUS_RDATA = 32'h0;
      forever begin
         @(negedge CLK);
         if (BUS_REQ) begin
            cyc++;
            if (cyc == 1) begin
               if (rsp_q.size() > 0) begin
                  cur = rsp_q.pop_front();
               end else begin
                  cur.delay = 1000;
                  cur.rdata = 32'h0;
               end
            end
            if (cyc == cur.delay + 1) begin
               BUS_ACK   = 1'b1;
               BUS_RDATA = cur.rdata;
            end else begin
               BUS_ACK   = 1'b0;
               BUS_RDATA = $urandom;
            end
         end else begin
            cyc       = 0;
            BUS_ACK   = 1'($urandom_range(0, 1));
            BUS_RDATA = $urandom;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      int   reqc;
      exp_t e;
      reqc = 0;
      forever begin
         @(negedge CLK);
         if (!mon_en) begin
            reqc = 0;
            continue;
         end
         if (BUS_REQ) begin
            if (reqc == 0) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_bus_req: got request, expected none at %0t", $time);
               end else begin
                  e = exp_q[0];
                  check("bus_we", BUS_WE, e.we);
                  check("bus_addr", BUS_ADDR, e.addr);
                  check("bus_be", BUS_BE, e.be);
                  if (e.we) check("bus_wdata", BUS_WDATA, e.wdata);
               end
            end
            reqc++;
         end else begin
            check("idle_be_we", {BUS_BE, BUS_WE}, 0);
         end
         if (LSU_DONE) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: got LSU_DONE, expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("req_cycles", reqc, e.req_cycles);
               check("misalign", MISALIGN, e.mis);
               check("bus_timeout", BUS_TIMEOUT, e.tmo);
               check("rdata_out", RDATA_OUT, e.rdata_out);
            end
            reqc = 0;
         end else begin
            check("flags_quiet", {MISALIGN, BUS_TIMEOUT}, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          k, size, wcnt;
      logic [31:0] addr;
      rsp_t        hang;
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      BYTE_SEL  = 2'b00;
      SIGN      = 1'b0;
      ADDR      = 32'h0;
      WDATA     = 32'h0;
      RST_N     = 1'b1;
      #1 RST_N  = 1'b0;
      #11;
      check("rst_bus_req", BUS_REQ, 0);
      check("rst_lsu_done", LSU_DONE, 0);
      check("rst_rdata_out", RDATA_OUT, 0);
      check("rst_bus_addr", BUS_ADDR, 0);
      check("rst_bus_wdata", BUS_WDATA, 0);
      check("rst_be_we_flags", {BUS_BE, BUS_WE, MISALIGN, BUS_TIMEOUT, LSU_STALL}, 0);
      @(negedge CLK);
      RST_N  = 1'b1;
      mon_en = 1'b1;
      @(negedge CLK);

      // Directed accesses.
      do_txn(1, 0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      do_txn(1, 0, 0, 1, 32'h103, 32'h0, 32'h80112233, 1);
      do_txn(1, 0, 0, 0, 32'h103, 32'h0, 32'h80112233, 0);
      do_txn(0, 1, 1, 0, 32'h202, 32'h0000ABCD, 32'h0, 0);
      do_txn(1, 0, 2, 0, 32'h101, 32'h0, 32'h0, 0);
      do_txn(1, 0, 1, 1, 32'h201, 32'h0, 32'h0, 0);
      do_txn(0, 1, 2, 0, 32'h300, 32'h12345678, 32'h0, TO);
      do_txn(0, 1, 2, 0, 32'h304, 32'h87654321, 32'h0, TO - 1);
      do_txn(1, 0, 2, 0, 32'h308, 32'h0, 32'h11112222, TO + 3);
      do_txn(1, 1, 2, 0, 32'h400, 32'hCAFEF00D, 32'h55555555, 2);
      do_txn(1, 0, 1, 1, 32'h102, 32'h0, 32'h8001_7F00, 0);
      do_txn(1, 0, 3, 1, 32'h10C, 32'h0, 32'hA5A5_0F0F, 1);
      do_txn(0, 1, 0, 0, 32'h501, 32'hFFFF_FF3C, 32'h0, 0);

      // Random accesses.
      for (int i = 0; i < 80; i++) begin
         k    = $urandom_range(0, 2);
         size = $urandom_range(0, 3);
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (size >= 2) addr[1:0] = 2'b00;
            else if (size == 1) addr[0] = 1'b0;
         end
         do_txn(k != 1, k != 0, size, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                $urandom_range(0, TO + 1));
      end

      // Reset in the middle of a bus access.
      mon_en     = 1'b0;
      hang.delay = 1000;
      hang.rdata = 32'h0;
      rsp_q.push_back(hang);
      MEM_READ = 1'b1;
      BYTE_SEL = 2'b10;
      SIGN     = 1'b0;
      ADDR     = 32'h500;
      wcnt = 0;
      while (!BUS_REQ && wcnt < 10) begin
         @(negedge CLK);
         wcnt++;
      end
      check("rsttest_req_seen", BUS_REQ, 1);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("rsttest_req_drops", BUS_REQ, 0);
      check("rsttest_no_done", LSU_DONE, 0);
      MEM_READ = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         check("rsttest_hold_quiet", {BUS_REQ, LSU_DONE}, 0);
      end
      check("rsttest_rdata_cleared", RDATA_OUT, 0);
      RST_N = 1'b1;
      rsp_q.delete();
      exp_q.delete();
      model_rdata = 32'h0;
      @(negedge CLK);
      check("rsttest_after_release", {BUS_REQ, LSU_DONE}, 0);
      mon_en = 1'b1;
      do_txn(1, 0, 2, 0, 32'h600, 32'h0, 32'h0BADF00D, 1);

      repeat (3) @(negedge CLK);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
